// File: rtl/layer_pixel_fetch.sv
// layer_pixel_fetch: stage 4 of the GPU layer pipe.
// Takes the RAM byte offset, flash bit offset and read enables from the
// address stage, fetches the glyph bit from font flash and/or the colour
// word from RAM, and presents one resolved pixel (colour + opacity).
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   start                    one-cycle pipeline advance; inputs sampled here
//   ramEn, flashEn, isSprite per-pixel fetch controls
//   ramBaseBytes, ramAddressOffsetBytes     RAM byte address terms
//   flashBaseBits, flashAddressOffsetBits   flash bit address terms
//   ramReq/ramAddr/ramAck/ramData           RAM word read handshake
//   flashReq/flashAddr/flashAck/flashData   flash byte read handshake
//   rdy                      idle or done, ready for start
//   pixelValid, pixelColor, pixelOpaque     resolved pixel
//   timeoutErr               sticky request-timeout flag
//   overrun                  pulse when start arrives while busy
module layer_pixel_fetch #(
    parameter logic [15:0] TRANSPARENT_COLOR = 16'hF81F,
    parameter int unsigned TIMEOUT_CYCLES    = 'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ramEn,
    input  logic        flashEn,
    input  logic        isSprite,
    input  logic [26:0] ramBaseBytes,
    input  logic [26:0] ramAddressOffsetBytes,
    input  logic [29:0] flashBaseBits,
    input  logic [29:0] flashAddressOffsetBits,
    output logic        ramReq,
    output logic [25:0] ramAddr,
    input  logic        ramAck,
    input  logic [15:0] ramData,
    output logic        flashReq,
    output logic [26:0] flashAddr,
    input  logic        flashAck,
    input  logic [7:0]  flashData,
    output logic        rdy,
    output logic        pixelValid,
    output logic [15:0] pixelColor,
    output logic        pixelOpaque,
    output logic        timeoutErr,
    output logic        overrun
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned RAM_AW    = 26;
    localparam int unsigned FLASH_AW  = 27;
    localparam int unsigned COLOR_W   = 16;
    // Last wait count at which a request may still be acknowledged; an
    // unanswered request at this count has been up TIMEOUT_CYCLES cycles.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FLASH_REQ = 2'd1,
        ST_RAM_REQ   = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic                ram_req_q, ram_req_d;
    logic                flash_req_q, flash_req_d;
    logic                rdy_q, rdy_d;
    logic                pixel_valid_q, pixel_valid_d;
    logic [COLOR_W-1:0]  pixel_color_q, pixel_color_d;
    logic                pixel_opaque_q, pixel_opaque_d;
    logic                timeout_err_q, timeout_err_d;
    logic                overrun_q, overrun_d;
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic [FLASH_AW-1:0] flash_addr_q, flash_addr_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic                ram_en_q, ram_en_d;
    logic                is_sprite_q, is_sprite_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

    logic [29:0]         flash_sum_c;
    logic                glyph_bit_c;
    logic                wait_expired_c;

    // Flash bit address: byte address in the upper bits, bit index below.
    assign flash_sum_c    = flashBaseBits + flashAddressOffsetBits;
    // Glyph rows are stored MSB-first, so bit index i lives at bit 7-i.
    assign glyph_bit_c    = flashData[~bit_idx_q];
    assign wait_expired_c = (wait_cnt_q == WAIT_LAST);

    // State and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            ram_req_q      <= 1'b0;
            flash_req_q    <= 1'b0;
            rdy_q          <= 1'b1;
            pixel_valid_q  <= 1'b0;
            pixel_color_q  <= '0;
            pixel_opaque_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            overrun_q      <= 1'b0;
            ram_addr_q     <= '0;
            flash_addr_q   <= '0;
            bit_idx_q      <= '0;
            ram_en_q       <= 1'b0;
            is_sprite_q    <= 1'b0;
            wait_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            ram_req_q      <= ram_req_d;
            flash_req_q    <= flash_req_d;
            rdy_q          <= rdy_d;
            pixel_valid_q  <= pixel_valid_d;
            pixel_color_q  <= pixel_color_d;
            pixel_opaque_q <= pixel_opaque_d;
            timeout_err_q  <= timeout_err_d;
            overrun_q      <= overrun_d;
            ram_addr_q     <= ram_addr_d;
            flash_addr_q   <= flash_addr_d;
            bit_idx_q      <= bit_idx_d;
            ram_en_q       <= ram_en_d;
            is_sprite_q    <= is_sprite_d;
            wait_cnt_q     <= wait_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Sprites never read flash, whatever flashEn says.
                    if (flashEn && !isSprite) begin
                        state_d = ST_FLASH_REQ;
                    end else if (ramEn) begin
                        state_d = ST_RAM_REQ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FLASH_REQ: begin
                if (flashAck) begin
                    state_d = (glyph_bit_c && ram_en_q) ? ST_RAM_REQ : ST_DONE;
                end else if (wait_expired_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_RAM_REQ: begin
                if (ramAck || wait_expired_c) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        pixel_color_d  = pixel_color_q;
        pixel_opaque_d = pixel_opaque_q;
        timeout_err_d  = timeout_err_q;
        ram_addr_d     = ram_addr_q;
        flash_addr_d   = flash_addr_q;
        bit_idx_d      = bit_idx_q;
        ram_en_d       = ram_en_q;
        is_sprite_d    = is_sprite_q;
        overrun_d      = 1'b0;

        // Handshake and status flags follow the state being entered.
        ram_req_d      = (state_d == ST_RAM_REQ);
        flash_req_d    = (state_d == ST_FLASH_REQ);
        rdy_d          = (state_d == ST_IDLE) || (state_d == ST_DONE);
        pixel_valid_d  = (state_d == ST_DONE);

        // Wait counter restarts on every state change, counts while waiting.
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if ((state_q == ST_FLASH_REQ) || (state_q == ST_RAM_REQ)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Word address: 27-bit byte sum wraps, then drop bit 0.
                    ram_addr_d     = RAM_AW'((ramBaseBytes + ramAddressOffsetBytes) >> 1);
                    flash_addr_d   = flash_sum_c[29:3];
                    bit_idx_d      = flash_sum_c[2:0];
                    ram_en_d       = ramEn;
                    is_sprite_d    = isSprite;
                    // Result defaults to transparent black until a RAM word lands.
                    pixel_color_d  = '0;
                    pixel_opaque_d = 1'b0;
                end
            end
            ST_FLASH_REQ: begin
                overrun_d = start;
                if (!flashAck && wait_expired_c) begin
                    timeout_err_d = 1'b1;
                end
            end
            ST_RAM_REQ: begin
                overrun_d = start;
                if (ramAck) begin
                    pixel_color_d  = ramData;
                    pixel_opaque_d = !(is_sprite_q && (ramData == TRANSPARENT_COLOR));
                end else if (wait_expired_c) begin
                    timeout_err_d  = 1'b1;
                    pixel_color_d  = '0;
                    pixel_opaque_d = 1'b0;
                end
            end
            default: begin
                overrun_d = 1'b0;
            end
        endcase
    end

    assign ramReq      = ram_req_q;
    assign ramAddr     = ram_addr_q;
    assign flashReq    = flash_req_q;
    assign flashAddr   = flash_addr_q;
    assign rdy         = rdy_q;
    assign pixelValid  = pixel_valid_q;
    assign pixelColor  = pixel_color_q;
    assign pixelOpaque = pixel_opaque_q;
    assign timeoutErr  = timeout_err_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/layer_pixel_fetch.md
# layer_pixel_fetch

Pipeline stage 4 of the GPU layer pipe. It sits directly downstream of the stage-3 address calculation unit and consumes its RAM byte offset, flash bit offset and read enables for one layer/pixel. It fetches the glyph bit from font flash and/or the 16-bit colour word from RAM, then presents one resolved pixel (colour plus opacity) to the compositor. It runs memory handshakes with a per-request timeout and holds its result until the next pipeline advance.

## Interface
- `TRANSPARENT_COLOR`, default 16'hF81F: sprite colour key; a matching RAM word is treated as transparent.
- `TIMEOUT_CYCLES`, default 'd255: cycles a request may remain unacknowledged before it is aborted.
- `clk` in 1: clock, 50 MHz maximum.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse per pipeline advance; inputs below are sampled on this cycle.
- `ramEn` in 1: RAM read needed.
- `flashEn` in 1: flash read needed (text layer).
- `isSprite` in 1: 1 = sprite layer, 0 = text layer.
- `ramBaseBytes` in 27: layer RAM base address.
- `ramAddressOffsetBytes` in 27: offset from stage 3.
- `flashBaseBits` in 30: font base address in flash.
- `flashAddressOffsetBits` in 30: offset from stage 3.
- `ramReq` out 1: RAM read request.
- `ramAddr` out 26: 16-bit word address.
- `ramAck` in 1: RAM data valid.
- `ramData` in 16: RAM read word.
- `flashReq` out 1: flash read request.
- `flashAddr` out 27: flash byte address.
- `flashAck` in 1: flash data valid.
- `flashData` in 8: flash read byte.
- `rdy` out 1: stage idle or done; ready for `start`.
- `pixelValid` out 1: result registers hold a completed fetch.
- `pixelColor` out 16: RGB565 colour.
- `pixelOpaque` out 1: 1 = pixel is drawn.
- `timeoutErr` out 1: sticky; set when any request times out.
- `overrun` out 1: one-cycle pulse when `start` arrives while busy.

## Operation
- States: IDLE, FLASH_REQ, RAM_REQ, DONE.
- `start` is accepted only in IDLE or DONE. On acceptance:
  - Capture all inputs.
  - Compute ramAddr = (ramBaseBytes + ramAddressOffsetBytes)[26:1]; sum is 27 bits, wraps modulo 2^27, bit 0 dropped.
  - Compute flash sum = flashBaseBits + flashAddressOffsetBits (30 bits, wrapping). flashAddr = sum[29:3]; bit index = sum[2:0].
  - Clear `pixelValid`.
- Next state after accepted start:
  - flashEn=1: FLASH_REQ. This applies to text layers; flashEn on a sprite is ignored and treated as 0.
  - Otherwise ramEn=1: RAM_REQ.
  - Otherwise: DONE, with pixelOpaque=0 and pixelColor=0.
- FLASH_REQ: `flashReq` is held high with a stable address until `flashAck`. On ack, glyph bit = flashData[7 − bitIndex] (MSB-first).
  - Bit 1 and ramEn=1: go to RAM_REQ.
  - Otherwise: go to DONE, transparent.
- RAM_REQ: `ramReq` is held high until `ramAck`. On ack:
  - pixelColor = ramData.
  - pixelOpaque = !(isSprite && ramData == TRANSPARENT_COLOR). Text foreground is always opaque.
  - Go to DONE.
- Request timeout: a 16-bit wait counter clears on entering a REQ state and increments each cycle without ack. When it reaches TIMEOUT_CYCLES, drop the request, set `timeoutErr`, and go to DONE transparent (colour 0).
- DONE: `pixelValid`=1 and outputs are held. A new `start` re-enters the flow as from IDLE.
- `start` in FLASH_REQ or RAM_REQ is ignored: it pulses `overrun` and leaves state and captured inputs unchanged.
- An ack arriving when its request is not asserted is ignored.
- `timeoutErr` clears only on reset.

## Timing
- Reset (rst=0 at a clock edge):
  - State → IDLE.
  - ramReq, flashReq, pixelValid, pixelOpaque, timeoutErr, overrun = 0.
  - pixelColor, ramAddr, flashAddr = 0.
  - rdy = 1.
  - Reset mid-request drops the request in the next cycle.
- `start` sampled at edge N:
  - Request asserted from N+1.
  - Ack sampled at edge M.
  - Request deasserted from M+1.
  - Next request (if any) asserted from M+1.
- Minimum latencies (ack on the first request cycle):
  - Sprite: start@0, ramReq@1, ack@1, pixelValid@2.
  - Text foreground: flashReq@1, ack@1, ramReq@2, ack@2, pixelValid@3.
  - No fetch: pixelValid@1.
- `rdy` is registered: 0 from the cycle after an accepted start until DONE is reached.
- `rdy` and `pixelValid` rise together.
- Timeout: with no ack, the request is high for exactly TIMEOUT_CYCLES cycles.

## Test plan
- Sprite opaque: ramBase=0x100, offset=0x24, ramEn=1, ramData=0x07E0 ack after 3 cycles → ramAddr=0x92, pixelColor=0x07E0, opaque=1, pixelValid 1 cycle after ack.
- Sprite colour key: ramData=0xF81F → pixelValid=1, pixelOpaque=0, no timeoutErr.
- Text glyph: flash sum=0x0000_000B, flashData=0x10, ramData=0xFFFF → flashAddr=0x1, bit 4 set, RAM read issued, colour 0xFFFF, opaque=1. Same with flashData=0xEF → no ramReq, opaque=0.
- Disabled layer: ramEn=flashEn=0 → no requests, pixelValid next cycle, opaque=0, rdy stays high.
- Timeout: TIMEOUT_CYCLES=4, never ack → ramReq high exactly 4 cycles, timeoutErr=1 sticky, transparent result; next fetch succeeds with timeoutErr still 1.
- Overrun and reset: `start` during RAM_REQ → overrun pulse, address unchanged. rst=0 mid-request → ramReq=0 next cycle, all outputs at reset values, rdy=1.
